// File: rtl/speed2phase_if.sv
// Command/phase bus of the speed-to-phase generator.
// The master supplies speed commands and sample strobes and receives the phase stream.
interface speed2phase_if;
    logic signed [15:0] speed_in;
    logic               speed_valid;
    logic               speed_ready;
    logic               sample;
    logic signed [18:0] phase;
    logic               phase_valid;
    logic               frame_done;
    logic               busy;

    modport master (
        output speed_in, speed_valid, sample,
        input  speed_ready, phase, phase_valid, frame_done, busy
    );

    modport slave (
        input  speed_in, speed_valid, sample,
        output speed_ready, phase, phase_valid, frame_done, busy
    );
endinterface

// File: rtl/speed2phase.sv
// Speed-to-phase generator: each accepted 6Q10 speed command integrates 2^N
// sample-strobed steps into a 9Q10 phase wrapped to [-PI_Q, PI_Q).
module speed2phase #(
    parameter int N      = 6,
    parameter int K      = 1,
    parameter int KSHIFT = 0,
    parameter int PI_Q   = 3217
) (
    input  logic         clock,
    input  logic         reset,
    speed2phase_if.slave bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [15:0]        K_U       = K[15:0];
    localparam logic signed [32:0] STEP_MAX  = 33'(2 * PI_Q - 1);
    localparam logic signed [32:0] STEP_MIN  = -33'(2 * PI_Q - 1);
    localparam logic signed [19:0] PI20      = 20'(PI_Q);
    localparam logic signed [19:0] TWO_PI20  = 20'(2 * PI_Q);
    localparam logic [N:0]         FRAME_LEN = {1'b1, {N{1'b0}}};
    localparam logic [N:0]         CNT_ONE   = {{N{1'b0}}, 1'b1};

    state_t             r_state;
    logic [N:0]         r_cnt;
    logic signed [15:0] r_spd_q;
    logic signed [18:0] r_phase;
    logic               r_phase_valid;
    logic               r_frame_done;
    logic               r_busy;
    logic               r_ready;

    state_t             w_state_nxt;
    logic [N:0]         w_cnt_nxt;
    logic signed [15:0] w_spd_nxt;
    logic signed [18:0] w_phase_nxt;
    logic               w_pv_nxt;
    logic               w_fd_nxt;

    logic signed [32:0] w_spd_ext;
    logic signed [32:0] w_k_ext;
    logic signed [32:0] w_prod;
    logic signed [32:0] w_shifted;
    logic signed [32:0] w_sat;
    logic signed [19:0] w_step;
    logic signed [19:0] w_sum;
    logic signed [19:0] w_wrap20;
    logic signed [18:0] w_wrapped;

    // K is unsigned, so it enters the signed product zero-extended.
    assign w_spd_ext = 33'(r_spd_q);
    assign w_k_ext   = $signed({17'd0, K_U});
    assign w_prod    = w_spd_ext * w_k_ext;
    assign w_shifted = w_prod >>> KSHIFT;

    // Step saturation keeps |step| < 2*PI_Q so one wrap correction is enough.
    always_comb begin
        w_sat = w_shifted;
        if (w_shifted > STEP_MAX) begin
            w_sat = STEP_MAX;
        end else if (w_shifted < STEP_MIN) begin
            w_sat = STEP_MIN;
        end else begin
            w_sat = w_shifted;
        end
    end

    assign w_step = w_sat[19:0];
    assign w_sum  = 20'(r_phase) + w_step;

    // Modulo-2*pi wrap of the integrated phase.
    always_comb begin
        w_wrap20 = w_sum;
        if (w_sum >= PI20) begin
            w_wrap20 = w_sum - TWO_PI20;
        end else if (w_sum < -PI20) begin
            w_wrap20 = w_sum + TWO_PI20;
        end else begin
            w_wrap20 = w_sum;
        end
    end

    assign w_wrapped = w_wrap20[18:0];

    // Next-state and next-output logic of the frame controller.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_spd_nxt   = r_spd_q;
        w_phase_nxt = r_phase;
        w_pv_nxt    = 1'b0;
        w_fd_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.speed_valid) begin
                    w_spd_nxt   = bus.speed_in;
                    w_cnt_nxt   = FRAME_LEN;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.sample) begin
                    w_phase_nxt = w_wrapped;
                    w_pv_nxt    = 1'b1;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_fd_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_spd_q       <= 16'sd0;
            r_phase       <= 19'sd0;
            r_phase_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_spd_q       <= w_spd_nxt;
            r_phase       <= w_phase_nxt;
            r_phase_valid <= w_pv_nxt;
            r_frame_done  <= w_fd_nxt;
            r_busy        <= (w_state_nxt == ST_RUN);
            r_ready       <= (w_state_nxt == ST_IDLE);
        end
    end

    assign bus.phase       = r_phase;
    assign bus.phase_valid = r_phase_valid;
    assign bus.frame_done  = r_frame_done;
    assign bus.busy        = r_busy;
    assign bus.speed_ready = r_ready;
endmodule

// File: tb/tb_speed2phase.sv
// Self-checking bench: two instances (K=1 and K=4, N=2) against a modulo-arithmetic model
// compared every cycle, plus hand-computed phase expectations.
module tb_speed2phase;
    localparam int PI = 3217;
    localparam int NN = 2;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    speed2phase_if if_a ();
    speed2phase_if if_b ();

    speed2phase #(.N(NN), .K(1), .KSHIFT(0), .PI_Q(PI)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a.slave));
    speed2phase #(.N(NN), .K(4), .KSHIFT(0), .PI_Q(PI)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model state, index 0 = dut_a, 1 = dut_b.
    int m_phase [2];
    int m_step  [2];
    int m_left  [2];
    bit m_run   [2];
    bit m_pv    [2];
    bit m_fd    [2];

    function automatic int wrap_mod(int x);
        int y;
        y = (x + PI) % (2 * PI);
        if (y < 0) y = y + 2 * PI;
        return y - PI;
    endfunction

    function automatic int step_of(int spd, int k);
        longint p;
        p = longint'(spd) * longint'(k);
        if (p > 2 * PI - 1) p = 2 * PI - 1;
        if (p < -(2 * PI - 1)) p = -(2 * PI - 1);
        return int'(p);
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs the DUTs see.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            bit v, s;
            int spd;
            v   = (i == 0) ? if_a.speed_valid : if_b.speed_valid;
            s   = (i == 0) ? if_a.sample : if_b.sample;
            spd = (i == 0) ? int'(if_a.speed_in) : int'(if_b.speed_in);
            m_pv[i] = 1'b0;
            m_fd[i] = 1'b0;
            if (reset) begin
                m_phase[i] = 0;
                m_run[i]   = 1'b0;
                m_left[i]  = 0;
                m_step[i]  = 0;
            end else if (!m_run[i]) begin
                if (v) begin
                    m_step[i] = step_of(spd, (i == 0) ? 1 : 4);
                    m_left[i] = 1 << NN;
                    m_run[i]  = 1'b1;
                end
            end else if (s) begin
                m_phase[i] = wrap_mod(m_phase[i] + m_step[i]);
                m_pv[i]    = 1'b1;
                m_left[i]  = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_fd[i]  = 1'b1;
                    m_run[i] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (!$isunknown(reset)) begin
            int pa, pb;
            pa = int'(if_a.phase);
            pb = int'(if_b.phase);
            chk("a_phase", pa, m_phase[0]);
            chk("a_pvalid", if_a.phase_valid, m_pv[0]);
            chk("a_fdone", if_a.frame_done, m_fd[0]);
            chk("a_busy", if_a.busy, m_run[0]);
            chk("a_ready", if_a.speed_ready, !m_run[0]);
            chk("a_range", (pa >= -PI && pa <= PI - 1), 1);
            chk("b_phase", pb, m_phase[1]);
            chk("b_pvalid", if_b.phase_valid, m_pv[1]);
            chk("b_fdone", if_b.frame_done, m_fd[1]);
            chk("b_busy", if_b.busy, m_run[1]);
            chk("b_ready", if_b.speed_ready, !m_run[1]);
            chk("b_range", (pb >= -PI && pb <= PI - 1), 1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int ph(int d);
        return (d == 0) ? int'(if_a.phase) : int'(if_b.phase);
    endfunction

    // Accept a command; a sample strobe in the same cycle must be ignored.
    task automatic accept(int d, int spd);
        if (d == 0) begin
            if_a.speed_in = 16'(spd); if_a.speed_valid = 1'b1; if_a.sample = 1'b1;
        end else begin
            if_b.speed_in = 16'(spd); if_b.speed_valid = 1'b1; if_b.sample = 1'b1;
        end
        tick();
        if (d == 0) begin
            if_a.speed_valid = 1'b0; if_a.sample = 1'b0;
        end else begin
            if_b.speed_valid = 1'b0; if_b.sample = 1'b0;
        end
    endtask

    task automatic samp(int d, int exp_phase, string name);
        if (d == 0) if_a.sample = 1'b1; else if_b.sample = 1'b1;
        tick();
        if (d == 0) if_a.sample = 1'b0; else if_b.sample = 1'b0;
        chk(name, ph(d), exp_phase);
    endtask

    initial begin
        reset = 1'b1;
        if_a.speed_in = 16'sd0; if_a.speed_valid = 1'b0; if_a.sample = 1'b0;
        if_b.speed_in = 16'sd0; if_b.speed_valid = 1'b0; if_b.sample = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_phase", int'(if_a.phase), 0);
        chk("rst_ready", if_a.speed_ready, 1);
        chk("rst_busy", if_a.busy, 0);

        accept(0, 100);
        chk("acc_phase_hold", int'(if_a.phase), 0);
        chk("acc_busy", if_a.busy, 1);
        samp(0, 100, "f1_s1");
        samp(0, 200, "f1_s2");
        samp(0, 300, "f1_s3");
        samp(0, 400, "f1_s4");
        chk("f1_done", if_a.frame_done, 1);
        chk("f1_ready_back", if_a.speed_ready, 1);
        tick();

        accept(0, 1000);
        if_a.speed_in = 16'sd999;
        if_a.speed_valid = 1'b1;
        samp(0, 1400, "f2_s1");
        chk("f2_ready_low", if_a.speed_ready, 0);
        tick();
        chk("f2_hold", int'(if_a.phase), 1400);
        samp(0, 2400, "f2_s2");
        samp(0, -3034, "f2_poswrap");
        samp(0, -2034, "f2_s4");
        if_a.speed_valid = 1'b0;
        chk("f2_done", if_a.frame_done, 1);
        tick();

        accept(0, -1000);
        samp(0, -3034, "f3_s1");
        samp(0, 2400, "f3_negwrap");
        samp(0, 1400, "f3_s3");
        samp(0, 400, "f3_s4");
        tick();

        accept(0, 0);
        samp(0, 400, "f0_s1");
        samp(0, 400, "f0_s2");
        samp(0, 400, "f0_s3");
        samp(0, 400, "f0_s4");
        chk("f0_done", if_a.frame_done, 1);
        tick();

        accept(0, 77);
        samp(0, 477, "fr_s1");
        samp(0, 554, "fr_s2");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_phase", int'(if_a.phase), 0);
        chk("mid_rst_busy", if_a.busy, 0);
        chk("mid_rst_ready", if_a.speed_ready, 1);
        accept(0, 50);
        samp(0, 50, "f5_s1");
        samp(0, 100, "f5_s2");
        samp(0, 150, "f5_s3");
        samp(0, 200, "f5_s4");
        tick();

        accept(1, 32767);
        samp(1, -1, "sat_s1");
        samp(1, -2, "sat_s2");
        samp(1, -3, "sat_s3");
        samp(1, -4, "sat_s4");
        tick();
        accept(1, -32768);
        samp(1, -3, "nsat_s1");
        samp(1, -2, "nsat_s2");
        samp(1, -1, "nsat_s3");
        samp(1, 0, "nsat_s4");
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
